// File: rtl/mesi_isc_broad_snoop_cntl.sv
// mesi_isc_broad_snoop_cntl: broadcast FIFO consumer that snoops the other CPUs, then grants the originator
//
// Ports:
//   clk                clock, all state on rising edge
//   rst                asynchronous active-low reset
//   broad_fifo_empty_i broadcast FIFO empty (show-ahead head valid when low)
//   broad_addr_i       head entry address
//   broad_type_i       head entry type (0 NOP, 1 WR, 2 RD, 3 illegal)
//   broad_cpu_id_i     head entry originating CPU
//   broad_id_i         head entry transaction id
//   broad_fifo_rd_o    pop pulse to the broadcast FIFO
//   cbus_ack_array_i   per-CPU ack pulses, bit n = CPU n
//   cbus_cmd_array_o   per-CPU command lanes, lane n at [(n+1)*W-1:n*W]
//   cbus_addr_o        address of the in-flight request
//   broad_id_o         id of the in-flight request
//   busy_o             high from pop until the grant is acknowledged
module mesi_isc_broad_snoop_cntl #(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_fifo_empty_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    output logic                        broad_fifo_rd_o,
    input  logic [3:0]                  cbus_ack_array_i,
    output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic [BROAD_ID_WIDTH-1:0]   broad_id_o,
    output logic                        busy_o
);
    localparam logic [BROAD_TYPE_WIDTH-1:0] BT_WR = BROAD_TYPE_WIDTH'(1);
    localparam logic [BROAD_TYPE_WIDTH-1:0] BT_RD = BROAD_TYPE_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, SNOOP, GRANT} state_t;

    state_t     state;
    logic       pop_d;
    logic       wr_r;
    logic [1:0] cpu_r;
    logic [3:0] mask;
    logic       pop;
    logic       valid;
    logic [3:0] mask_nxt;

    // The cycle after a pop the FIFO head has not advanced yet, so the pop is masked;
    // rst gating keeps the pop low while reset is held.
    assign pop      = rst && state == IDLE && !broad_fifo_empty_i && !pop_d;
    assign valid    = broad_type_i == BT_WR || broad_type_i == BT_RD;
    assign mask_nxt = mask & ~cbus_ack_array_i;

    assign broad_fifo_rd_o = pop;
    assign busy_o          = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pop_d       <= 1'b0;
            wr_r        <= 1'b0;
            cpu_r       <= 2'd0;
            mask        <= 4'd0;
            cbus_addr_o <= '0;
            broad_id_o  <= '0;
        end else begin
            pop_d <= pop;
            case (state)
                IDLE: if (pop) begin
                    cbus_addr_o <= broad_addr_i;
                    broad_id_o  <= broad_id_i;
                    wr_r        <= broad_type_i == BT_WR;
                    cpu_r       <= broad_cpu_id_i;
                    mask        <= valid ? ~(4'b0001 << broad_cpu_id_i) : 4'd0;
                    state       <= valid ? SNOOP : IDLE;
                end
                SNOOP: begin
                    mask <= mask_nxt;
                    if (mask_nxt == 4'd0) state <= GRANT;
                end
                GRANT: if (cbus_ack_array_i[cpu_r]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign cbus_cmd_array_o[g*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
            (state == SNOOP && mask[g])        ? (wr_r ? CMD_WR_SNOOP : CMD_RD_SNOOP) :
            (state == GRANT && cpu_r == 2'(g)) ? (wr_r ? CMD_EN_WR : CMD_EN_RD) :
            CMD_NOP;
    end
endmodule
